// File: rtl/fp_addsub_arbiter_pkg.sv
// fp_arb_pkg: shared constants and types for the fp_addsub_arbiter slice.
//   OP_ADD / OP_SUB : encodings of dp_operation_select / req_op
//   MAX_REQ, ID_W   : requester limit and width of a requester ID
//   arb_tag_t       : one stage of the in-flight tag pipeline
package fp_arb_pkg;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned ID_W    = 4;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } arb_tag_t;

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// fp_addsub_arbiter_if: requester and datapath signals of the shared add/sub unit.
//   req_valid/req_ready/req_a/req_b/req_op : per-requester issue handshake (packed)
//   rsp_valid/rsp_result                   : one-hot response owner and result
//   dp_a/dp_b/dp_operation_select          : registered operands to add_sub_main
//   dp_result                              : result from add_sub_main
//   busy                                   : at least one operation in flight
// Modports: slave = the arbiter, master = requesters plus datapath side.
interface fp_addsub_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_REQ = 4
);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_op;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_result;
    logic [WIDTH-1:0]       dp_a;
    logic [WIDTH-1:0]       dp_b;
    logic                   dp_operation_select;
    logic [WIDTH-1:0]       dp_result;
    logic                   busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, dp_result,
        output req_ready, rsp_valid, rsp_result, dp_a, dp_b, dp_operation_select, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, dp_result,
        input  req_ready, rsp_valid, rsp_result, dp_a, dp_b, dp_operation_select, busy
    );

endinterface

// File: rtl/fp_addsub_arbiter_rr_arbiter.sv
// fp_rr_arbiter: combinational grant for N_REQ requesters.
//   clk, rst      : clock, synchronous active-high reset (forces no grant)
//   i_req_valid   : request vector
//   o_grant       : one-hot grant, subset of i_req_valid
//   o_grant_any   : a grant is issued this cycle
//   o_grant_idx   : index of the granted requester
// Build option FP_ARB_ROUND_ROBIN_EN: defined = round-robin with a pointer register
// (search starts after the last grant); undefined = fixed priority, lowest index wins.
module fp_rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req_valid,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_grant_any,
    output logic [ID_W-1:0]  o_grant_idx
);

    logic            w_lo_found;
    logic [ID_W-1:0] w_lo_idx;

    // Lowest-index valid requester; the fallback (wrap) choice in both builds.
    always_comb begin
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (i_req_valid[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = ID_W'(i);
            end
        end
    end

    assign o_grant_any = !rst && w_lo_found;

`ifdef FP_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_ptr;
    logic            w_hi_found;
    logic [ID_W-1:0] w_hi_idx;

    // Lowest valid index strictly above the pointer; if none, wrap to w_lo_idx.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (i_req_valid[i] && (i > int'(r_ptr)) && !w_hi_found) begin
                w_hi_found = 1'b1;
                w_hi_idx   = ID_W'(i);
            end
        end
    end

    assign o_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= ID_W'(N_REQ - 1);
        end else if (o_grant_any) begin
            r_ptr <= o_grant_idx;
        end
    end
`else
    logic w_unused_clk;
    assign w_unused_clk = clk;
    assign o_grant_idx  = w_lo_idx;
`endif

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            o_grant[i] = o_grant_any && (o_grant_idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: shares one add_sub_main datapath among N_REQ requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fp_addsub_arbiter_if.slave (issue handshake, response, datapath port, busy)
// Accepts at most one operation per cycle, registers its operands into the datapath and
// carries the requester ID through a LATENCY+1 deep tag shift register so the result
// comes back as a one-hot rsp_valid pulse. No stall: responses must be taken when shown.
// Arbitration policy selected by FP_ARB_ROUND_ROBIN_EN (see fp_rr_arbiter).
module fp_addsub_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst,
    fp_addsub_arbiter_if.slave  bus
);

    logic [N_REQ-1:0] w_grant;
    logic             w_grant_any;
    logic [ID_W-1:0]  w_grant_idx;

    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_op;

    logic [WIDTH-1:0] r_dp_a;
    logic [WIDTH-1:0] r_dp_b;
    logic             r_dp_op;

    arb_tag_t         r_tag [LATENCY+1];
    logic             w_busy;
    logic [N_REQ-1:0] w_rsp_valid;

    fp_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (bus.req_valid),
        .o_grant     (w_grant),
        .o_grant_any (w_grant_any),
        .o_grant_idx (w_grant_idx)
    );

    // One-hot operand mux driven by the grant vector.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = OP_ADD;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_grant[i]) begin
                w_sel_a  = bus.req_a[i*WIDTH +: WIDTH];
                w_sel_b  = bus.req_b[i*WIDTH +: WIDTH];
                w_sel_op = bus.req_op[i];
            end
        end
    end

    // Operands hold their value when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_a  <= '0;
            r_dp_b  <= '0;
            r_dp_op <= OP_ADD;
        end else if (w_grant_any) begin
            r_dp_a  <= w_sel_a;
            r_dp_b  <= w_sel_b;
            r_dp_op <= w_sel_op;
        end
    end

    // Stage k holds the tag whose operands entered the datapath k cycles ago; the last
    // stage lines up with the cycle dp_result is valid for that operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= int'(LATENCY); k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_grant_any, id: w_grant_idx};
            for (int k = 1; k <= int'(LATENCY); k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k <= int'(LATENCY); k++) begin
            w_busy = w_busy | r_tag[k].valid;
        end
    end

    // Gated by rst so an operation accepted before reset never produces a response.
    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_rsp_valid[i] = !rst && r_tag[LATENCY].valid && (r_tag[LATENCY].id == ID_W'(i));
        end
    end

    assign bus.req_ready           = w_grant;
    assign bus.dp_a                = r_dp_a;
    assign bus.dp_b                = r_dp_b;
    assign bus.dp_operation_select = r_dp_op;
    assign bus.rsp_valid           = w_rsp_valid;
    assign bus.rsp_result          = bus.dp_result;
    assign bus.busy                = w_busy && !rst;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench for fp_addsub_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic, all against a cycle-level reference
// model (pointer + in-flight queue). A 1-cycle behavioural add/sub stands in for
// add_sub_main. Follows FP_ARB_ROUND_ROBIN_EN for the expected arbitration policy.
module tb_fp_addsub_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 1;

    typedef struct {
        int          id;
        logic [31:0] res;
        int          due;
    } inflight_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rsp;
        logic [31:0] exp_res;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_addsub_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

    fp_addsub_arbiter #(
        .WIDTH   (W),
        .N_REQ   (N),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Drive values for the next cycle.
    logic         d_rst;
    logic [N-1:0] d_v;
    logic [W-1:0] d_a [N];
    logic [W-1:0] d_b [N];
    logic [N-1:0] d_op;

    // Observed values of the last cycle.
    logic [N-1:0] obs_ready;
    logic [N-1:0] obs_rsp;
    logic [W-1:0] obs_result;
    logic         obs_dp_op;
    logic         obs_busy;

    // Reference model state.
    int           m_ptr;
    inflight_t    m_q[$];
    logic [W-1:0] m_dp_a;
    logic [W-1:0] m_dp_b;
    logic         m_dp_op;

    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
        return op ? r2sp(sp2r(a) + sp2r(b)) : r2sp(sp2r(a) - sp2r(b));
    endfunction

    // 1-cycle add_sub_main stand-in.
    always @(posedge clk) begin
        bus.dp_result <= fp_op(bus.dp_a, bus.dp_b, bus.dp_operation_select);
    end

    function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
`ifdef FP_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: apply drives, sample, compare against the model, advance model.
    task automatic step();
        int           g;
        logic [N-1:0] er;
        logic [N-1:0] erv;
        logic [W-1:0] eres;
        inflight_t    it;
        @(posedge clk);
        #1;
        rst           = d_rst;
        bus.req_valid = d_v;
        bus.req_op    = d_op;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = d_a[i];
            bus.req_b[i*W +: W] = d_b[i];
        end
        #1;
        obs_ready  = bus.req_ready;
        obs_rsp    = bus.rsp_valid;
        obs_result = bus.rsp_result;
        obs_dp_op  = bus.dp_operation_select;
        obs_busy   = bus.busy;

        g  = d_rst ? -1 : exp_grant(d_v, m_ptr);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("ready", 32'(obs_ready), 32'(er));
        check("busy", 32'(obs_busy), 32'(!d_rst && m_q.size() > 0));
        check("dp_a", bus.dp_a, m_dp_a);
        check("dp_b", bus.dp_b, m_dp_b);
        check("dp_op", 32'(obs_dp_op), 32'(m_dp_op));

        erv  = '0;
        eres = '0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            it = m_q.pop_front();
            if (!d_rst) erv[it.id] = 1'b1;
            eres = it.res;
        end
        check("rsp_valid", 32'(obs_rsp), 32'(erv));
        if (erv != '0) check("rsp_result", obs_result, eres);

        if (d_rst) begin
            m_q.delete();
            m_ptr   = N - 1;
            m_dp_a  = '0;
            m_dp_b  = '0;
            m_dp_op = 1'b1;
        end else if (g >= 0) begin
            it.id  = g;
            it.res = fp_op(d_a[g], d_b[g], d_op[g]);
            it.due = cyc + 1 + LAT;
            m_q.push_back(it);
            m_ptr   = g;
            m_dp_a  = d_a[g];
            m_dp_b  = d_b[g];
            m_dp_op = d_op[g];
        end
        cyc++;
    endtask

    task automatic do_reset();
        d_rst = 1'b1;
        d_v   = '0;
        step();
        step();
        d_rst = 1'b0;
    endtask

    function automatic logic [3:0] exp_all4(input int k);
`ifdef FP_ARB_ROUND_ROBIN_EN
        return 4'(1 << (k % 4));
`else
        return 4'b0001;
`endif
    endfunction

    function automatic logic [3:0] exp_13(input int k);
`ifdef FP_ARB_ROUND_ROBIN_EN
        return (k % 2 == 0) ? 4'b0010 : 4'b1000;
`else
        return 4'b0010;
`endif
    endfunction

    vec_t tbl [6];

    initial begin
        tbl[0] = '{0, 32'h3F800000, 32'h40000000, 1'b1, 4'b0001, 4'b0001, 32'h40400000};
        tbl[1] = '{2, 32'h40400000, 32'h3F800000, 1'b0, 4'b0100, 4'b0100, 32'h40000000};
        tbl[2] = '{1, 32'h40000000, 32'h40000000, 1'b1, 4'b0010, 4'b0010, 32'h40800000};
        tbl[3] = '{3, 32'h3F800000, 32'h40400000, 1'b0, 4'b1000, 4'b1000, 32'hC0000000};
        tbl[4] = '{0, 32'h40000000, 32'h40000000, 1'b0, 4'b0001, 4'b0001, 32'h00000000};
        tbl[5] = '{3, 32'h40400000, 32'h40400000, 1'b1, 4'b1000, 4'b1000, 32'h40C00000};

        m_ptr   = N - 1;
        m_dp_a  = '0;
        m_dp_b  = '0;
        m_dp_op = 1'b1;
        d_rst   = 1'b1;
        d_v     = '0;
        d_op    = '0;
        for (int i = 0; i < N; i++) begin
            d_a[i] = '0;
            d_b[i] = '0;
        end
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;

        do_reset();
        step();
        check("reset_dp_op", 32'(obs_dp_op), 32'd1);
        check("reset_busy", 32'(obs_busy), 32'd0);

        // Directed single-issue vectors.
        for (int e = 0; e < 6; e++) begin
            d_a[tbl[e].id]  = tbl[e].a;
            d_b[tbl[e].id]  = tbl[e].b;
            d_op[tbl[e].id] = tbl[e].op;
            d_v = 4'(1 << tbl[e].id);
            step();
            check("tbl_ready", 32'(obs_ready), 32'(tbl[e].exp_ready));
            d_v = '0;
            step();
            check("tbl_dp_op", 32'(obs_dp_op), 32'(tbl[e].op));
            step();
            check("tbl_rsp_valid", 32'(obs_rsp), 32'(tbl[e].exp_rsp));
            check("tbl_rsp_result", obs_result, tbl[e].exp_res);
        end

        // All four requesters held valid for eight cycles.
        do_reset();
        for (int i = 0; i < N; i++) begin
            d_a[i]  = r2sp(real'(i + 1));
            d_b[i]  = 32'h3F800000;
            d_op[i] = 1'b1;
        end
        for (int c = 0; c < 10; c++) begin
            d_v = (c < 8) ? 4'hF : 4'h0;
            step();
            if (c < 8) check("all4_grant", 32'(obs_ready), 32'(exp_all4(c)));
            if (c >= 2) check("all4_rsp", 32'(obs_rsp), 32'(exp_all4(c - 2)));
        end

        // Requesters 1 and 3 held valid after reset.
        do_reset();
        d_v = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            step();
            check("pair13_grant", 32'(obs_ready), 32'(exp_13(c)));
        end
        d_v = '0;
        step();
        step();

        // Reset in the cycle after an issue drops the response.
        d_v = 4'b0001;
        step();
        check("rst_issue", 32'(obs_ready), 32'd1);
        d_v   = '0;
        d_rst = 1'b1;
        step();
        check("rst_ready_low", 32'(obs_ready), 32'd0);
        d_rst = 1'b0;
        step();
        check("rst_rsp_drop", 32'(obs_rsp), 32'd0);
        check("rst_busy", 32'(obs_busy), 32'd0);
        d_v = 4'b0110;
        step();
        check("rst_next_grant", 32'(obs_ready), 32'b0010);
        d_v = '0;
        step();

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            d_rst = ($urandom_range(0, 49) == 0);
            d_v   = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                d_a[i]  = r2sp(real'($urandom_range(0, 63)));
                d_b[i]  = r2sp(real'($urandom_range(0, 63)));
                d_op[i] = 1'($urandom_range(0, 1));
            end
            step();
        end
        d_rst = 1'b0;
        d_v   = '0;
        for (int c = 0; c < 4; c++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Round-robin arbiter and issue controller that shares one `add_sub_main` floating-point add/sub datapath among `N_REQ` requesters. It accepts one operation per cycle over a valid/ready handshake and registers the operands into the datapath. It tracks the requester ID of every in-flight operation through the datapath latency, then routes the result back as a one-hot response. It sits directly in front of the `add_sub_main` instance.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width (IEEE-754 single).
- `N_REQ`, 4: number of requesters, 2..16.
- `LATENCY`, 1: cycles from `dp_*` change to a valid `dp_result`; must be ≥1.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  request pending, one bit per requester.
- `req_ready`  out  N_REQ  one-hot grant; handshake occurs when `req_valid[i] & req_ready[i]`.
- `req_a`  in  N_REQ*WIDTH  operand A, requester i at `[i*WIDTH +: WIDTH]`.
- `req_b`  in  N_REQ*WIDTH  operand B, same packing.
- `req_op`  in  N_REQ  1 = add, 0 = subtract.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle pulse marking the result owner.
- `rsp_result`  out  WIDTH  result; meaningful only while `rsp_valid != 0`.
- `dp_a`, `dp_b`  out  WIDTH  registered datapath operands.
- `dp_operation_select`  out  1  registered datapath op.
- `dp_result`  in  WIDTH  datapath result.
- `busy`  out  1  at least one operation in flight.

## Operation
- Grant is combinational from `req_valid` and the priority pointer. At most one `req_ready` bit is high, and only alongside its own `req_valid`. `req_ready` is 0 while `rst` is high.
- Round-robin: search starts at `ptr+1` mod `N_REQ` and wraps. On each grant, `ptr` ← granted index. No grant leaves `ptr` unchanged.
- On grant of requester g: `dp_a`, `dp_b`, `dp_operation_select` ← `req_a[g]`, `req_b[g]`, `req_op[g]`. A tag {valid=1, id=g} enters the tag pipeline.
- No grant: `dp_*` hold their value; the tag entering the pipeline has valid=0.
- Tag pipeline is a shift register, `LATENCY+1` deep, shifting every cycle. There is no stall and no backpressure; requesters must accept `rsp_valid` unconditionally.
- At the last tag stage: `rsp_valid` = one-hot(id) if valid, else 0. `rsp_result` = `dp_result` pass-through.
- `busy` = OR of all tag valid bits.
- A requester may hold `req_valid` across cycles and issue back-to-back when re-granted. The block allows no operand reordering and does not buffer responses.
- Reset values: `ptr` = `N_REQ-1` (requester 0 first), all tags invalid, `dp_a` = `dp_b` = 0, `dp_operation_select` = 1, `rsp_valid` = 0, `busy` = 0.
- Reset mid-operation: all in-flight tags are discarded. No `rsp_valid` ever appears for operations accepted before `rst`.

## Timing
- Handshake in cycle t → `dp_*` valid in t+1 → `rsp_valid` pulse in t+1+`LATENCY` (t+2 at default).
- Throughput is one operation per cycle, sustained.
- Simultaneous grant and response in the same cycle is the normal case and is independent.
- Responses return in issue order.

## Configuration
- `FP_ARB_ROUND_ROBIN_EN` defined: round-robin as described above.
- Undefined: fixed priority. The lowest-index valid requester always wins, and `ptr` is not implemented.
- Handshake, latency and tag behaviour are identical in both builds.

## Structure
- Package `fp_arb_pkg`:
  - `OP_ADD` = 1'b1, `OP_SUB` = 1'b0.
  - `MAX_REQ` = 16, `ID_W` = 4.
  - `arb_tag_t` struct {logic valid; logic [ID_W-1:0] id}.
- Sub-module `fp_rr_arbiter`: `N_REQ`-wide grant logic plus pointer register. The macro is evaluated here.
- Top level holds the operand registers, the tag pipeline and response decode.

## Test plan
Default parameters; `dp_result` driven by a 1-cycle `add_sub_main` model. Constants: 1.0 = 0x3F800000, 2.0 = 0x40000000, 3.0 = 0x40400000.
- req0 only, add 0x3F800000 + 0x40000000 → `req_ready` = 4'b0001 in cycle t; `rsp_valid` = 4'b0001 at t+2 with `rsp_result` = 0x40400000.
- req2 only, sub 0x40400000 − 0x3F800000 → `dp_operation_select` = 0 at t+1; `rsp_valid` = 4'b0100 at t+2 with `rsp_result` = 0x40000000.
- All four `req_valid` high for 8 cycles, RR build → grants 0,1,2,3,0,1,2,3; `rsp_valid` follows the same order two cycles later, one per cycle.
- Same stimulus, macro undefined → `req_ready` = 4'b0001 every cycle; `rsp_valid` = 4'b0001 from t+2 onward.
- Requesters 1 and 3 held valid after reset, RR build → grants alternate 1,3,1,3; `ptr` wraps correctly.
- Issue at t, `rst` high in t+1 → `rsp_valid` stays 0 at t+2; `busy` = 0 after reset; the next request after reset is granted to the lowest-index valid requester.
